// File: rtl/sample_descrambler.sv
// sample_descrambler
//   Receive-side descrambler for the sampling scrambler link. Serial scrambled
//   bits arrive one per bit_valid/bit_ready handshake and are descrambled by a
//   self-synchronising 8-bit LFSR (taps 0 and 6). Recovered bits are packed
//   MSB-first into bytes and presented on a single-entry byte_valid/byte_ready
//   buffer. frame_done pulses once the last byte of a FRAME_BITS-bit frame has
//   been handed downstream.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   enable     : block enable; low synchronously returns to IDLE and clears all
//   load       : seed load / frame start strobe
//   seed       : LFSR seed captured on load
//   bit_valid  : serial bit present
//   bit_in     : scrambled serial bit
//   bit_ready  : block accepts bit_in this cycle
//   byte_valid : byte_o holds a recovered byte
//   byte_o     : recovered byte, first-received bit in bit 7
//   byte_ready : downstream accepts byte_o
//   frame_done : one-cycle pulse after the frame's last byte is taken
module sample_descrambler #(
  parameter int unsigned FRAME_BITS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       bit_ready,
  output logic       byte_valid,
  output logic [7:0] byte_o,
  input  logic       byte_ready,
  output logic       frame_done
);

  localparam int unsigned     FCW     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [FCW-1:0]  FC_LAST = FCW'(FRAME_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]     state;
  logic [7:0]     s;
  logic [2:0]     bitcnt;
  logic [FCW-1:0] framecnt;
  logic [6:0]     assembly;

  logic rec;
  logic accept;
  logic drain;

  // Self-synchronising: the state holds received (scrambled) bits, not
  // recovered ones, so a receiver with a wrong seed heals after 7 bits.
  assign rec = bit_in ^ s[0] ^ s[6];

  // Only the byte-completing bit needs a free buffer; a buffer draining in
  // the same cycle counts as free.
  assign bit_ready = (state == RUN) &&
                     !((bitcnt == 3'd7) && byte_valid && !byte_ready);
  assign accept    = bit_valid && bit_ready;
  assign drain     = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      s          <= '0;
      bitcnt     <= '0;
      framecnt   <= '0;
      assembly   <= '0;
      byte_o     <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      s          <= '0;
      bitcnt     <= '0;
      framecnt   <= '0;
      assembly   <= '0;
      byte_o     <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A handshake on the output always completes; a byte finishing on this
      // same edge overrides it below by re-setting byte_valid.
      if (drain) begin
        byte_valid <= 1'b0;
      end

      if ((state != IDLE) && load) begin
        // Restart mid-frame: the partial byte is dropped but a byte already in
        // the output buffer is still delivered.
        s        <= seed;
        bitcnt   <= '0;
        framecnt <= '0;
        assembly <= '0;
        state    <= RUN;
      end else begin
        case (state)
          IDLE: begin
            if (load) begin
              s     <= seed;
              state <= RUN;
            end
          end
          RUN: begin
            if (accept) begin
              s        <= {s[6:0], bit_in};
              assembly <= {assembly[5:0], rec};
              bitcnt   <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                byte_o     <= {assembly, rec};
                byte_valid <= 1'b1;
              end
              if (framecnt == FC_LAST) begin
                framecnt <= '0;
                state    <= FLUSH;
              end else begin
                framecnt <= framecnt + FCW'(1);
              end
            end
          end
          FLUSH: begin
            if (!byte_valid || byte_ready) begin
              frame_done <= 1'b1;
              state      <= IDLE;
              s          <= '0;
              bitcnt     <= '0;
              framecnt   <= '0;
              assembly   <= '0;
              byte_o     <= '0;
              byte_valid <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_descrambler.sv
module tb_sample_descrambler;

  localparam int FB = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       load;
  logic [7:0] seed;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       byte_valid;
  logic [7:0] byte_o;
  logic       byte_ready;
  logic       frame_done;

  always #5 clk = ~clk;

  sample_descrambler #(.FRAME_BITS(FB)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .seed       (seed),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_ready  (bit_ready),
    .byte_valid (byte_valid),
    .byte_o     (byte_o),
    .byte_ready (byte_ready),
    .frame_done (frame_done)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference: frame progress, received-bit history and the
  // single output slot. Recovered bits come from the history formula
  // r[k] = b[k] ^ b[k-1] ^ b[k-7], with seed bits standing in before bit 0.
  int         m_state;   // 0 idle, 1 receiving, 2 waiting for last byte
  int         m_cnt;
  logic       m_bits[$];
  logic [7:0] m_seed;
  logic       m_full;
  logic [7:0] m_byte;
  logic       m_done;

  logic       tx[$];
  logic [7:0] got[$];
  int         done_seen = 0;
  int         accepted  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic recov(input int k);
    logic a, c;
    a = (k >= 1) ? m_bits[k-1] : m_seed[0];
    c = (k >= 7) ? m_bits[k-7] : m_seed[6-k];
    return m_bits[k] ^ a ^ c;
  endfunction

  function automatic logic [7:0] model_byte(input int j);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = recov(8*j + i);
    return b;
  endfunction

  task automatic model_clear();
    m_state = 0;
    m_cnt   = 0;
    m_bits.delete();
    m_seed  = '0;
    m_full  = 1'b0;
    m_byte  = '0;
    m_done  = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; checks, advances the
  // model across the next edge, and returns at posedge+1.
  task automatic tick();
    logic exp_ready, acc, drn, nd;
    #1;
    exp_ready = (m_state == 1) && !(((m_cnt % 8) == 7) && m_full && !byte_ready);
    chk("bit_ready", 32'(bit_ready), 32'(exp_ready));
    chk("byte_valid", 32'(byte_valid), 32'(m_full));
    if (m_full) chk("byte_o", 32'(byte_o), 32'(m_byte));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    if (frame_done === 1'b1) done_seen++;
    if (byte_valid === 1'b1 && byte_ready) got.push_back(byte_o);
    acc = bit_valid && exp_ready;
    drn = m_full && byte_ready;
    nd  = 1'b0;
    if (!enable) begin
      model_clear();
    end else if (m_state != 0 && load) begin
      m_seed = seed;
      m_bits.delete();
      m_cnt   = 0;
      m_state = 1;
      if (drn) m_full = 1'b0;
    end else if (m_state == 0) begin
      if (load) begin
        m_seed  = seed;
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (drn) m_full = 1'b0;
      if (acc) begin
        m_bits.push_back(bit_in);
        m_cnt++;
        accepted++;
        if (m_cnt % 8 == 0) begin
          m_byte = model_byte(m_cnt/8 - 1);
          m_full = 1'b1;
        end
        if (m_cnt == FB) m_state = 2;
      end
    end else begin
      if (!m_full || byte_ready) begin
        model_clear();
        nd = 1'b1;
      end
    end
    m_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int mode);
    case (mode)
      0:       byte_ready = 1'b0;
      1:       byte_ready = 1'b1;
      default: byte_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic send(input int n, input int ready_mode, input bit rnd_valid, input int budget);
    int start, cyc, prev;
    start = accepted;
    cyc   = 0;
    while ((accepted - start) < n && cyc < budget) begin
      bit_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      bit_in    = (tx.size() != 0) ? tx[0] : 1'b0;
      set_ready(ready_mode);
      prev = accepted;
      tick();
      if (accepted != prev && tx.size() != 0) void'(tx.pop_front());
      cyc++;
    end
    bit_valid = 1'b0;
    chk("bits_sent", 32'(accepted - start), 32'(n));
  endtask

  task automatic finish_frame(input int ready_mode, input int budget);
    int cyc, d0;
    d0  = done_seen;
    cyc = 0;
    while (m_state != 0 && cyc < budget) begin
      set_ready(ready_mode);
      tick();
      cyc++;
    end
    bit_valid = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;
    chk("frame_done_count", 32'(done_seen - d0), 32'd1);
  endtask

  task automatic load_seed(input logic [7:0] sd);
    load      = 1'b1;
    seed      = sd;
    bit_valid = 1'b0;
    tick();
    load = 1'b0;
  endtask

  task automatic fill_tx_random(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(1'($urandom()));
  endtask

  task automatic random_frame(input int tag);
    got.delete();
    load_seed(8'($urandom()));
    fill_tx_random(FB);
    send(FB, 2, 1'b1, 600);
    finish_frame(2, 100);
    chk($sformatf("rand%0d_nbytes", tag), 32'(got.size()), 32'd8);
  endtask

  initial begin
    logic [7:0] e0;
    int         a0, d0;

    rst = 1'b0; enable = 1'b0; load = 1'b0; seed = '0;
    bit_valid = 1'b0; bit_in = 1'b0; byte_ready = 1'b0;
    model_clear();

    #12;
    chk("rst_bit_ready", 32'(bit_ready), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_o", 32'(byte_o), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // load while disabled does nothing
    load_seed(8'h55);
    enable    = 1'b1;
    bit_valid = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;

    // seed 0x00, a single 1 then zeros
    got.delete();
    load_seed(8'h00);
    tx.delete();
    tx.push_back(1'b1);
    for (int i = 0; i < FB - 1; i++) tx.push_back(1'b0);
    send(FB, 1, 1'b0, 200);
    finish_frame(1, 50);
    chk("t1_nbytes", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      chk("t1_byte0", 32'(got[0]), 32'h0C1);
      for (int i = 1; i < 8; i++) chk($sformatf("t1_byte%0d", i), 32'(got[i]), 32'h00);
    end

    // seed 0x01, all zeros
    got.delete();
    load_seed(8'h01);
    tx.delete();
    for (int i = 0; i < FB; i++) tx.push_back(1'b0);
    send(FB, 1, 1'b0, 200);
    finish_frame(1, 50);
    chk("t2_nbytes", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      chk("t2_byte0", 32'(got[0]), 32'h82);
      for (int i = 1; i < 8; i++) chk($sformatf("t2_byte%0d", i), 32'(got[i]), 32'h00);
    end

    // backpressure from the first byte onward
    got.delete();
    load_seed(8'h01);
    tx.delete();
    for (int i = 0; i < FB; i++) tx.push_back(1'b0);
    send(15, 0, 1'b0, 40);
    a0 = accepted;
    for (int i = 0; i < 6; i++) begin
      bit_valid  = 1'b1;
      bit_in     = 1'b0;
      byte_ready = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    chk("t3_stalled", 32'(accepted - a0), 32'd0);
    chk("t3_hold_byte", 32'(byte_o), 32'h82);
    chk("t3_hold_valid", 32'(byte_valid), 32'd1);
    send(FB - 15, 1, 1'b0, 200);
    finish_frame(1, 50);
    chk("t3_nbytes", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      chk("t3_byte0", 32'(got[0]), 32'h82);
      for (int i = 1; i < 8; i++) chk($sformatf("t3_byte%0d", i), 32'(got[i]), 32'h00);
    end

    // reload after 13 bits: partial byte dropped, buffered byte kept
    got.delete();
    load_seed(8'h00);
    fill_tx_random(13);
    send(13, 0, 1'b0, 40);
    e0 = m_byte;
    byte_ready = 1'b0;
    load_seed(8'h00);
    fill_tx_random(FB);
    send(FB, 2, 1'b0, 400);
    finish_frame(2, 100);
    chk("t4_nbytes", 32'(got.size()), 32'd9);
    if (got.size() != 0) chk("t4_first", 32'(got[0]), 32'(e0));

    // enable low for one cycle with a byte pending
    load_seed(8'($urandom()));
    fill_tx_random(10);
    send(10, 0, 1'b0, 40);
    chk("t5_pending", 32'(byte_valid), 32'd1);
    d0        = done_seen;
    enable    = 1'b0;
    bit_valid = 1'b1;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bit_valid = 1'b0;
    chk("t5_no_done", 32'(done_seen - d0), 32'd0);
    random_frame(5);

    // asynchronous reset mid-byte
    load_seed(8'($urandom()));
    fill_tx_random(5);
    send(5, 1, 1'b0, 20);
    d0 = done_seen;
    #2 rst = 1'b0;
    #1;
    chk("t6_bit_ready", 32'(bit_ready), 32'd0);
    chk("t6_byte_valid", 32'(byte_valid), 32'd0);
    chk("t6_byte_o", 32'(byte_o), 32'd0);
    chk("t6_frame_done", 32'(frame_done), 32'd0);
    model_clear();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bit_valid = 1'b0;
    chk("t6_no_done", 32'(done_seen - d0), 32'd0);
    random_frame(6);

    for (int f = 0; f < 3; f++) random_frame(7 + f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_descrambler.md
# sample_descrambler

Receive-side counterpart of the sampling scrambler. It accepts a serial scrambled bit stream one bit per handshake and recovers the original bits with a self-synchronising 8-bit LFSR using taps 0 and 6. It packs the recovered bits into bytes on a valid/ready byte interface and signals the end of each fixed-length frame. It sits between the serial link and the byte-wide datapath.

## Interface
- FRAME_BITS, 64, bits per frame; must be a multiple of 8, minimum 8.
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; low forces IDLE.
- load  input  1  seed load / frame start strobe.
- seed  input  8  LFSR seed, captured on load.
- bit_valid  input  1  serial bit present.
- bit_in  input  1  scrambled serial bit.
- bit_ready  output  1  block accepts bit_in this cycle.
- byte_valid  output  1  byte_o holds a recovered byte.
- byte_o  output  8  recovered byte, first-received bit in bit 7.
- byte_ready  input  1  downstream accepts byte_o.
- frame_done  output  1  one-cycle pulse after a frame's last byte is taken.

## Operation
- State register s[7:0]. A bit is accepted when bit_valid && bit_ready.
- On an accepted bit:
  - recovered bit r = bit_in ^ s[0] ^ s[6];
  - s <= {s[6:0], bit_in}, so the received scrambled bit shifts into s[0];
  - r shifts into the assembly register, MSB-first;
  - bitcnt (3 bits) and framecnt (log2(FRAME_BITS) bits) increment.
- When bitcnt wraps 7→0, the assembled byte moves into a single-entry output buffer and byte_valid is set.
- The output buffer empties when byte_valid && byte_ready.
- bit_ready = (state==RUN) && !(bitcnt==7 && byte_valid && !byte_ready). A byte completing in the same cycle the buffer drains is legal.
- FSM:
  - IDLE: s, counters, assembly register and output buffer are clear. enable && load: s<=seed, go RUN.
  - RUN: accept bits. The FRAME_BITS-th accepted bit goes to FLUSH.
  - FLUSH: bit_ready=0. When the buffer is empty, or drains this cycle, pulse frame_done and go IDLE.
- Priority, highest first:
  - !enable: synchronously go IDLE and clear everything, including a pending byte.
  - load in RUN or FLUSH: s<=seed, bitcnt/framecnt/assembly cleared, partial byte dropped, go RUN; the output buffer is kept.
  - bit acceptance.
- load with enable low has no effect.
- bit_valid is ignored in IDLE and FLUSH; no bit is consumed.

## Timing
- Reset values: bit_ready=0, byte_valid=0, byte_o=0x00, frame_done=0, state IDLE, s=0.
- The seed is usable on the cycle after load. bit_ready rises on the cycle after the load edge.
- Throughput is 1 bit/cycle with no bubbles while byte_ready=1.
- Latency: the edge that accepts the 8th bit of a byte raises byte_valid and updates byte_o on the same edge.
- byte_o and byte_valid are stable while byte_valid && !byte_ready.
- frame_done is high for exactly one cycle, starting the edge after the last byte's handshake, or after the 64th bit if the buffer is already empty. bit_ready is 0 during that cycle.
- Reset asserted mid-frame clears all state immediately. No frame_done follows.

## Test plan
- Seed 0x00, load, bits 1 then 63 zeros, byte_ready=1 → bytes 0xC1 then seven 0x00; frame_done one cycle after the 8th byte; bit_ready then 0.
- Seed 0x01, 64 zero bits → first byte 0x82, remaining bytes 0x00; exactly 8 byte handshakes.
- Backpressure: byte_ready=0 from the first byte onward → bit_ready drops while bitcnt==7; byte_o is held at 0x82; releasing byte_ready resumes with no lost or duplicated bits.
- load mid-frame after 13 bits, new seed 0x00 → 5-bit partial byte dropped; the already-buffered byte is still delivered; the frame restarts and gives 8 more bytes before frame_done.
- enable low for 1 cycle mid-frame while byte_valid=1 → byte_valid=0 and bit_ready=0 next cycle; no frame_done; a later load starts a clean frame.
- rst pulsed low asynchronously mid-byte → all outputs are 0 before the next clk edge and state is IDLE; bit_valid is ignored until enable && load.
